// File: rtl/tlc_phase_sequencer.sv
// Traffic-light phase sequencer: detects slow-clock ticks, steps NS/EW lamp phases
// with per-phase countdowns, and serves a latched pedestrian request with a WALK phase.
module tlc_phase_sequencer #(
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 5
) (
  input  logic       clk_osc,
  input  logic       RESET,
  input  logic       tick_clk,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic [7:0] remain_bcd
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED1   = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED2   = 3'd5,
    WALK      = 3'd6,
    ILLEGAL   = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t     state, state_nxt;
  logic [6:0] remain, remain_nxt;
  logic       pending, pending_nxt;
  logic       ack_nxt;
  logic       t1, t2;
  logic       tick;

  function automatic logic [6:0] duration(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   return 7'(T_GREEN);
      NS_YELLOW, EW_YELLOW: return 7'(T_YELLOW);
      ALLRED1, ALLRED2:     return 7'(T_ALLRED);
      WALK:                 return 7'(T_WALK);
      default:              return 7'(T_GREEN);
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {tens, units};
  endfunction

  // Tick detect: flops reset high so a post-reset rising edge is required
  assign tick = t1 & ~t2;

  always_ff @(posedge clk_osc) begin
    if (RESET) begin
      t1      <= 1'b1;
      t2      <= 1'b1;
      state   <= NS_GREEN;
      remain  <= 7'(T_GREEN);
      pending <= 1'b0;
      ped_ack <= 1'b0;
    end else begin
      t1      <= tick_clk;
      t2      <= t1;
      state   <= state_nxt;
      remain  <= remain_nxt;
      pending <= pending_nxt;
      ped_ack <= ack_nxt;
    end
  end

  // Phase advance and countdown
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    if (state == ILLEGAL) begin
      state_nxt  = NS_GREEN;
      remain_nxt = 7'(T_GREEN);
    end else if (tick) begin
      if (remain == 7'd1) begin
        case (state)
          NS_GREEN:  state_nxt = NS_YELLOW;
          NS_YELLOW: state_nxt = ALLRED1;
          ALLRED1:   state_nxt = EW_GREEN;
          EW_GREEN:  state_nxt = EW_YELLOW;
          EW_YELLOW: state_nxt = ALLRED2;
          ALLRED2:   state_nxt = pending ? WALK : NS_GREEN;
          default:   state_nxt = NS_GREEN;
        endcase
        remain_nxt = duration(state_nxt);
      end else if (remain > 7'd1) begin
        remain_nxt = remain - 7'd1;
      end
    end
  end

  // Pedestrian latch; the ALLRED2 exit above sees only the already-registered pending
  always_comb begin
    ack_nxt     = ped_req && !pending && (state != WALK);
    pending_nxt = pending;
    if ((state_nxt == WALK) && (state != WALK)) begin
      pending_nxt = 1'b0;
    end else if (ack_nxt) begin
      pending_nxt = 1'b1;
    end
  end

  always_comb begin
    ns_light = LAMP_R;
    ew_light = LAMP_R;
    walk     = 1'b0;
    case (state)
      NS_GREEN:  ns_light = LAMP_G;
      NS_YELLOW: ns_light = LAMP_Y;
      EW_GREEN:  ew_light = LAMP_G;
      EW_YELLOW: ew_light = LAMP_Y;
      WALK:      walk     = 1'b1;
      default:   ;
    endcase
  end

  assign phase      = state;
  assign remain_bcd = to_bcd(remain);

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Bench for tlc_phase_sequencer: tick-level phase model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_tlc_phase_sequencer;

  localparam int T_GREEN  = 10;
  localparam int T_YELLOW = 3;
  localparam int T_ALLRED = 1;
  localparam int T_WALK   = 5;

  logic       clk_osc = 1'b0;
  logic       RESET;
  logic       tick_clk;
  logic       ped_req;
  logic       ped_ack;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;
  logic [7:0] remain_bcd;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  int ack_count = 0;

  tlc_phase_sequencer #(
    .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED), .T_WALK(T_WALK)
  ) dut (
    .clk_osc(clk_osc), .RESET(RESET), .tick_clk(tick_clk), .ped_req(ped_req),
    .ped_ack(ped_ack), .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .phase(phase), .remain_bcd(remain_bcd)
  );

  always #10 clk_osc = ~clk_osc;

  // Reference model: phase table, durations and lamp tables per phase
  int dur_tab [7] = '{T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED, T_WALK};
  logic [2:0] ns_tab [7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

  logic m_prev1, m_prev2;
  int   m_ph, m_rem;
  logic m_pend, m_ack;

  function automatic int after(input int ph, input logic pend);
    if (ph == 5) return pend ? 6 : 0;
    if (ph == 6) return 0;
    return ph + 1;
  endfunction

  always @(posedge clk_osc) begin
    if (RESET) begin
      m_prev1 <= 1'b1;
      m_prev2 <= 1'b1;
      m_ph    <= 0;
      m_rem   <= T_GREEN;
      m_pend  <= 1'b0;
      m_ack   <= 1'b0;
    end else begin
      m_prev1 <= tick_clk;
      m_prev2 <= m_prev1;
      if (m_prev1 && !m_prev2) begin
        if (m_rem == 1) begin
          m_ph  <= after(m_ph, m_pend);
          m_rem <= dur_tab[after(m_ph, m_pend)];
        end else begin
          m_rem <= m_rem - 1;
        end
      end
      m_ack <= ped_req && !m_pend && (m_ph != 6);
      if (m_prev1 && !m_prev2 && m_rem == 1 && m_ph == 5 && m_pend)
        m_pend <= 1'b0;
      else if (ped_req && !m_pend && (m_ph != 6))
        m_pend <= 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_osc) begin
    if (chk_en) begin
      chk("phase", int'(phase), m_ph);
      chk("ns_light", int'(ns_light), int'(ns_tab[m_ph]));
      chk("ew_light", int'(ew_light), int'(ew_tab[m_ph]));
      chk("walk", int'(walk), (m_ph == 6) ? 1 : 0);
      chk("remain_bcd", int'(remain_bcd), ((m_rem / 10) << 4) | (m_rem % 10));
      chk("ped_ack", int'(ped_ack), int'(m_ack));
      if (ped_ack) ack_count++;
    end
  end

  task automatic do_tick();
    @(negedge clk_osc) tick_clk = 1'b1;
    repeat (2) @(negedge clk_osc);
    tick_clk = 1'b0;
    repeat (2) @(negedge clk_osc);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  initial begin
    RESET    = 1'b1;
    tick_clk = 1'b1;
    ped_req  = 1'b0;
    repeat (2) @(negedge clk_osc);
    chk_en = 1'b1;
    chk("rst_phase", int'(phase), 0);
    chk("rst_bcd", int'(remain_bcd), 8'h10);
    chk("rst_ns", int'(ns_light), 3'b001);
    chk("rst_ew", int'(ew_light), 3'b100);
    chk("rst_ack", int'(ped_ack), 0);
    RESET = 1'b0;

    // tick_clk high since reset: no tick until a fresh rise
    repeat (5) @(negedge clk_osc);
    chk("hold_high_bcd", int'(remain_bcd), 8'h10);
    tick_clk = 1'b0;
    repeat (3) @(negedge clk_osc);
    tick_clk = 1'b1;
    @(negedge clk_osc);
    chk("tick_lat1_bcd", int'(remain_bcd), 8'h10);
    @(negedge clk_osc);
    chk("tick_lat2_bcd", int'(remain_bcd), 8'h09);
    repeat (4) @(negedge clk_osc);
    chk("one_tick_bcd", int'(remain_bcd), 8'h09);
    tick_clk = 1'b0;
    repeat (2) @(negedge clk_osc);

    // remainder of a plain lap
    ticks(9);
    chk("lap_ph1", int'(phase), 1);
    chk("lap_ph1_bcd", int'(remain_bcd), 8'h03);
    chk("lap_ph1_ns", int'(ns_light), 3'b010);
    ticks(4);
    chk("lap_ph3", int'(phase), 3);
    chk("lap_ph3_ew", int'(ew_light), 3'b001);
    ticks(13);
    chk("lap_ph5", int'(phase), 5);
    ticks(1);
    chk("lap_end_ph", int'(phase), 0);
    chk("lap_end_bcd", int'(remain_bcd), 8'h10);

    // single request pulse during EW_GREEN
    ticks(14);
    @(negedge clk_osc) ped_req = 1'b1;
    @(negedge clk_osc);
    chk("pulse_ack_hi", int'(ped_ack), 1);
    ped_req = 1'b0;
    @(negedge clk_osc);
    chk("pulse_ack_lo", int'(ped_ack), 0);
    ticks(14);
    chk("walk_ph", int'(phase), 6);
    chk("walk_lamp", int'(walk), 1);
    ticks(5);
    chk("walk_exit_ph", int'(phase), 0);
    ticks(28);
    chk("nowalk_lap_ph", int'(phase), 0);
    chk("nowalk_lap_bcd", int'(remain_bcd), 8'h10);

    // request held for two laps: ack at start and after each WALK exit
    ack_count = 0;
    ped_req = 1'b1;
    ticks(66);
    chk("held_ack_count", ack_count, 3);
    ped_req = 1'b0;

    // reset mid EW_YELLOW with a request pending
    ticks(25);
    chk("pre_rst_ph", int'(phase), 4);
    @(negedge clk_osc) RESET = 1'b1;
    @(negedge clk_osc) RESET = 1'b0;
    chk("midrst_ph", int'(phase), 0);
    chk("midrst_bcd", int'(remain_bcd), 8'h10);
    chk("midrst_ns", int'(ns_light), 3'b001);
    chk("midrst_ew", int'(ew_light), 3'b100);
    ticks(28);
    chk("post_rst_nowalk", int'(phase), 0);

    // request on the very edge that expires ALLRED2
    ticks(27);
    chk("edge_pre_ph", int'(phase), 5);
    @(negedge clk_osc) tick_clk = 1'b1;
    @(negedge clk_osc) ped_req = 1'b1;
    @(negedge clk_osc) ped_req = 1'b0;
    chk("edge_ack", int'(ped_ack), 1);
    chk("edge_ph", int'(phase), 0);
    tick_clk = 1'b0;
    repeat (2) @(negedge clk_osc);
    ticks(28);
    chk("edge_next_walk", int'(phase), 6);
    ticks(5);
    chk("edge_walk_done", int'(phase), 0);

    @(negedge clk_osc);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
